exe_mem_pipe_reg: RTL and testbench

- Parametrised EXE->MEM pipeline register, successor to the fixed-field EXE/MEM latch.
- Carries a control bundle and a datapath bundle through DEPTH elastic slices with valid/ready handshake, stall via backpressure, flush via bubble insertion, and a skid entry per slice.
- Full throughput (1 transfer/cycle) under continuous ready.
- Exposes saturating stall and flush counters for performance debug.

---
 rtl/exe_mem_pipe_reg.sv | 144 ++++++++++++++
 tb/tb_exe_mem_pipe_reg.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/exe_mem_pipe_reg.sv
// Elastic EXE->MEM pipeline register: DEPTH cascaded main+skid slices with a
// valid/ready handshake, flush-to-bubble, and saturating stall/flush counters.
module exe_mem_pipe_reg #(
  parameter int CTRL_W = 11,
  parameter int DATA_W = 357,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic [DEPTH:0]    chainValid;
  logic [DEPTH:0]    chainReady;
  logic [CTRL_W-1:0] chainCtrl [DEPTH+1];
  logic [DATA_W-1:0] chainData [DEPTH+1];
  logic [DEPTH-1:0]  sliceBusy;

  assign chainValid[0]     = in_valid;
  assign chainCtrl[0]      = ctrl_in;
  assign chainData[0]      = data_in;
  assign in_ready          = chainReady[0];
  assign chainReady[DEPTH] = out_ready;
  assign out_valid         = chainValid[DEPTH];
  assign ctrl_out          = chainCtrl[DEPTH];
  assign data_out          = chainData[DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : gSlice
    logic              mainValid_q, mainValid_d;
    logic [CTRL_W-1:0] mainCtrl_q, mainCtrl_d;
    logic [DATA_W-1:0] mainData_q, mainData_d;
    logic              skidValid_q, skidValid_d;
    logic [CTRL_W-1:0] skidCtrl_q, skidCtrl_d;
    logic [DATA_W-1:0] skidData_q, skidData_d;
    logic              accept;
    logic              consume;

    // Ready depends only on our own skid flag, so backpressure never forms a
    // combinational path from out_ready back to in_ready.
    assign chainReady[k]   = !skidValid_q;
    assign chainValid[k+1] = mainValid_q;
    assign chainCtrl[k+1]  = mainCtrl_q;
    assign chainData[k+1]  = mainData_q;
    assign sliceBusy[k]    = mainValid_q | skidValid_q;

    assign accept  = chainValid[k] & !skidValid_q;
    assign consume = mainValid_q & chainReady[k+1];

    always_comb begin
      mainValid_d = mainValid_q;
      mainCtrl_d  = mainCtrl_q;
      mainData_d  = mainData_q;
      skidValid_d = skidValid_q;
      skidCtrl_d  = skidCtrl_q;
      skidData_d  = skidData_q;
      if (flush) begin
        mainValid_d = 1'b0;
        mainCtrl_d  = '0;
        skidValid_d = 1'b0;
        skidCtrl_d  = '0;
      end else if (consume) begin
        if (skidValid_q) begin
          mainValid_d = 1'b1;
          mainCtrl_d  = skidCtrl_q;
          mainData_d  = skidData_q;
          skidValid_d = 1'b0;
          skidCtrl_d  = '0;
        end else if (accept) begin
          mainCtrl_d  = chainCtrl[k];
          mainData_d  = chainData[k];
        end else begin
          mainValid_d = 1'b0;
          mainCtrl_d  = '0;
        end
      end else if (accept) begin
        if (!mainValid_q) begin
          mainValid_d = 1'b1;
          mainCtrl_d  = chainCtrl[k];
          mainData_d  = chainData[k];
        end else begin
          skidValid_d = 1'b1;
          skidCtrl_d  = chainCtrl[k];
          skidData_d  = chainData[k];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        mainValid_q <= 1'b0;
        mainCtrl_q  <= '0;
        mainData_q  <= '0;
        skidValid_q <= 1'b0;
        skidCtrl_q  <= '0;
        skidData_q  <= '0;
      end else begin
        mainValid_q <= mainValid_d;
        mainCtrl_q  <= mainCtrl_d;
        mainData_q  <= mainData_d;
        skidValid_q <= skidValid_d;
        skidCtrl_q  <= skidCtrl_d;
        skidData_q  <= skidData_d;
      end
    end
  end

  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
  logic [CNT_W-1:0] flushCnt_q, flushCnt_d;

  // Both counters stick at all-ones rather than wrapping.
  always_comb begin
    stallCnt_d = stallCnt_q;
    flushCnt_d = flushCnt_q;
    if (out_valid && !out_ready && stallCnt_q != '1)
      stallCnt_d = stallCnt_q + CNT_W'(1);
    if (flush && (|sliceBusy) && flushCnt_q != '1)
      flushCnt_d = flushCnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      stallCnt_q <= stallCnt_d;
      flushCnt_q <= flushCnt_d;
    end
  end

  assign stall_cnt = stallCnt_q;
  assign flush_cnt = flushCnt_q;

endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// Directed bench for exe_mem_pipe_reg (DEPTH=2, 4-bit counters) with a short
// randomised handshake phase checked against an in-order queue.
module tb_exe_mem_pipe_reg;

  localparam int CTRL_W = 11;
  localparam int DATA_W = 357;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              inValid;
  logic              inReady;
  logic [CTRL_W-1:0] ctrlIn;
  logic [DATA_W-1:0] dataIn;
  logic              flush;
  logic              outValid;
  logic              outReady;
  logic [CTRL_W-1:0] ctrlOut;
  logic [DATA_W-1:0] dataOut;
  logic [CNT_W-1:0]  stallCnt;
  logic [CNT_W-1:0]  flushCnt;

  int compared   = 0;
  int mismatched = 0;

  exe_mem_pipe_reg #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(inValid), .in_ready(inReady),
    .ctrl_in(ctrlIn), .data_in(dataIn),
    .flush(flush),
    .out_valid(outValid), .out_ready(outReady),
    .ctrl_out(ctrlOut), .data_out(dataOut),
    .stall_cnt(stallCnt), .flush_cnt(flushCnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                             input logic [DATA_W-1:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [CTRL_W-1:0] c,
                               input logic [DATA_W-1:0] d);
    inValid = v;
    ctrlIn  = c;
    dataIn  = d;
  endtask

  // Outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] mkData(input int unsigned s);
    logic [DATA_W-1:0] r;
    r = '0;
    r[31:0] = s;
    r[DATA_W-1 -: 32] = ~s;
    return r;
  endfunction

  function automatic logic [CTRL_W-1:0] mkCtrl(input int unsigned s);
    logic [31:0] t;
    t = s;
    return t[CTRL_W-1:0] | CTRL_W'(1);
  endfunction

  int unsigned expQ[$];
  int unsigned seq;
  int          received;
  int          cycles;

  initial begin
    rst = 1'b1; flush = 1'b0; outReady = 1'b0;
    applyStimulus(1'b0, '0, '0);
    tick(); tick();
    rst = 1'b0;
    checkOutput("reset_out_valid", outValid, 1'b0);
    checkOutput("reset_ctrl_out", ctrlOut, '0);
    checkOutput("reset_data_out", dataOut, '0);
    checkOutput("reset_in_ready", inReady, 1'b1);
    checkOutput("reset_stall_cnt", stallCnt, '0);
    checkOutput("reset_flush_cnt", flushCnt, '0);

    // Streaming: 1..4 back-to-back, visible DEPTH cycles after accept.
    outReady = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      if (i <= 4) applyStimulus(1'b1, 11'h1FF, DATA_W'(i));
      else        applyStimulus(1'b0, '0, '0);
      tick();
      checkOutput($sformatf("stream_valid_%0d", i), outValid, (i >= 2 && i <= 5));
      if (i >= 2 && i <= 5) begin
        checkOutput($sformatf("stream_data_%0d", i), dataOut, DATA_W'(i - 1));
        checkOutput($sformatf("stream_ctrl_%0d", i), ctrlOut, 11'h1FF);
      end else begin
        checkOutput($sformatf("stream_bubble_ctrl_%0d", i), ctrlOut, '0);
      end
    end
    checkOutput("stream_stall_cnt", stallCnt, '0);

    // Backpressure: capacity is 4 entries, 14 is refused.
    outReady = 1'b0;
    applyStimulus(1'b1, 11'h0F0, DATA_W'(10)); tick();
    checkOutput("bp_ready_a", inReady, 1'b1);
    applyStimulus(1'b1, 11'h0F0, DATA_W'(11)); tick();
    checkOutput("bp_ready_b", inReady, 1'b1);
    checkOutput("bp_valid_b", outValid, 1'b1);
    applyStimulus(1'b1, 11'h0F0, DATA_W'(12)); tick();
    checkOutput("bp_ready_c", inReady, 1'b1);
    checkOutput("bp_stall_c", stallCnt, 4'd1);
    applyStimulus(1'b1, 11'h0F0, DATA_W'(13)); tick();
    checkOutput("bp_ready_d", inReady, 1'b0);
    checkOutput("bp_stall_d", stallCnt, 4'd2);
    applyStimulus(1'b1, 11'h0F0, DATA_W'(14)); tick();
    checkOutput("bp_ready_e", inReady, 1'b0);
    checkOutput("bp_stall_e", stallCnt, 4'd3);
    checkOutput("bp_data_e", dataOut, DATA_W'(10));
    applyStimulus(1'b0, '0, '0);
    outReady = 1'b1;
    for (int i = 11; i <= 13; i++) begin
      tick();
      checkOutput($sformatf("drain_valid_%0d", i), outValid, 1'b1);
      checkOutput($sformatf("drain_data_%0d", i), dataOut, DATA_W'(i));
    end
    tick();
    checkOutput("drain_empty", outValid, 1'b0);
    checkOutput("drain_empty_ctrl", ctrlOut, '0);
    checkOutput("drain_stall", stallCnt, 4'd3);

    // Flush with two entries in flight and a concurrent input.
    outReady = 1'b0;
    applyStimulus(1'b1, 11'h3FF, DATA_W'(20)); tick();
    applyStimulus(1'b1, 11'h3FF, DATA_W'(21)); tick();
    checkOutput("preflush_valid", outValid, 1'b1);
    applyStimulus(1'b1, 11'h3FF, DATA_W'(22));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    applyStimulus(1'b0, '0, '0);
    checkOutput("flush_valid", outValid, 1'b0);
    checkOutput("flush_ctrl", ctrlOut, '0);
    checkOutput("flush_cnt_1", flushCnt, 4'd1);
    checkOutput("flush_stall", stallCnt, 4'd4);
    checkOutput("flush_in_ready", inReady, 1'b1);
    outReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("flush_no_ghost_%0d", i), outValid, 1'b0);
    end

    // Flush on an empty pipe is not counted.
    flush = 1'b1; tick(); flush = 1'b0;
    checkOutput("flush_empty_cnt", flushCnt, 4'd1);

    // Stall counter saturates at 15.
    outReady = 1'b0;
    applyStimulus(1'b1, 11'h155, DATA_W'(30)); tick();
    applyStimulus(1'b0, '0, '0);
    for (int i = 0; i < 20; i++) tick();
    checkOutput("sat_stall", stallCnt, 4'hF);
    checkOutput("sat_data", dataOut, DATA_W'(30));

    // Reset mid-stream together with flush.
    for (int i = 31; i <= 33; i++) begin
      applyStimulus(1'b1, 11'h155, DATA_W'(i)); tick();
    end
    checkOutput("prerst_full", inReady, 1'b0);
    applyStimulus(1'b1, 11'h155, DATA_W'(34));
    rst = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0;
    applyStimulus(1'b0, '0, '0);
    checkOutput("rst_valid", outValid, 1'b0);
    checkOutput("rst_ctrl", ctrlOut, '0);
    checkOutput("rst_data", dataOut, '0);
    checkOutput("rst_in_ready", inReady, 1'b1);
    checkOutput("rst_stall", stallCnt, '0);
    checkOutput("rst_flush", flushCnt, '0);

    // Random valid/ready traffic against an in-order queue.
    seq = 100; received = 0; cycles = 0;
    while (received < 300 && cycles < 4000) begin
      if (outValid) begin
        checkOutput("rand_data", dataOut, mkData(expQ[0]));
        checkOutput("rand_ctrl", ctrlOut, mkCtrl(expQ[0]));
      end else begin
        checkOutput("rand_bubble_ctrl", ctrlOut, '0);
      end
      outReady = ($urandom_range(0, 3) != 0);
      if (outValid && outReady) begin
        void'(expQ.pop_front());
        received++;
      end
      if ($urandom_range(0, 3) != 0) begin
        applyStimulus(1'b1, mkCtrl(seq), mkData(seq));
        if (inReady) begin
          expQ.push_back(seq);
          seq++;
        end
      end else begin
        applyStimulus(1'b0, '0, '0);
      end
      tick();
      cycles++;
    end
    checkOutput("rand_count", DATA_W'(received), DATA_W'(300));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
